// File: rtl/dh_game_ctl.sv
// dh_game_ctl - round and shot sequencer for Duck Hunt.
//
// Runs in the pixel-clock domain and counts all durations in frames
// (frame_tick pulses), so it does not depend on the display resolution.
//
// Ports:
//   clk, rst_n     - pixel clock, asynchronous active-low reset
//   frame_tick     - one-cycle pulse per frame
//   start          - one-cycle start/restart pulse (IDLE and GAME_OVER only)
//   trigger, hit   - one-cycle fire pulse; hit level sampled with the trigger
//   duck_en        - duck sprite visible
//   duck_respawn   - one-cycle pulse on the first cycle of a new duck
//   duck_falling   - shot-duck fall animation
//   duck_escaping  - escape animation
//   flash_en       - shot flash overlay
//   ammo           - shots remaining for the current duck
//   score          - total hits, saturating at 255
//   round          - current round, saturating at 15
//   game_over      - game-over screen
module dh_game_ctl #(
  parameter int AMMO_PER_DUCK      = 3,
  parameter int ROUND_START_FRAMES = 120,
  parameter int FLY_FRAMES         = 300,
  parameter int FLASH_FRAMES       = 2,
  parameter int FALL_FRAMES        = 60,
  parameter int ESCAPE_FRAMES      = 60,
  parameter int DUCKS_PER_ROUND    = 10,
  parameter int PASS_HITS          = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       trigger,
  input  logic       hit,
  output logic       duck_en,
  output logic       duck_respawn,
  output logic       duck_falling,
  output logic       duck_escaping,
  output logic       flash_en,
  output logic [1:0] ammo,
  output logic [7:0] score,
  output logic [3:0] round,
  output logic       game_over
);

  localparam int MAX_A      = (ROUND_START_FRAMES > FLASH_FRAMES) ? ROUND_START_FRAMES : FLASH_FRAMES;
  localparam int MAX_B      = (FALL_FRAMES > ESCAPE_FRAMES) ? FALL_FRAMES : ESCAPE_FRAMES;
  localparam int MAX_FRAMES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int FCW        = $clog2(MAX_FRAMES + 1);
  localparam int YW         = $clog2(FLY_FRAMES + 1);
  localparam int DW         = $clog2(DUCKS_PER_ROUND + 1);

  typedef enum logic [3:0] {
    IDLE, ROUND_START, FLY, FLASH, FALL, ESCAPE, NEXT, ROUND_END, GAME_OVER
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [FCW-1:0] frame_cnt;
  logic [FCW-1:0] frame_lim;
  logic           frame_done;
  logic [YW-1:0]  fly_cnt;
  logic [DW-1:0]  ducks_done;
  logic [DW-1:0]  round_hits;
  logic           shot_hit;
  logic           shot_ok;
  logic           launch;
  logic           enter;

  // Last count value of the timed states; the state ends on the tick that
  // would take frame_cnt past it, so the partial entry frame never counts.
  always_comb begin
    frame_lim = '0;
    case (state)
      ROUND_START: frame_lim = FCW'(ROUND_START_FRAMES - 1);
      FLASH:       frame_lim = FCW'(FLASH_FRAMES - 1);
      FALL:        frame_lim = FCW'(FALL_FRAMES - 1);
      ESCAPE:      frame_lim = FCW'(ESCAPE_FRAMES - 1);
      default:     frame_lim = '0;
    endcase
  end

  assign frame_done = frame_tick && (frame_cnt == frame_lim);

  // Next-state decision; a shot in FLY wins over the fly timeout.
  always_comb begin
    state_nxt = state;
    shot_ok   = (state == FLY) && trigger && (ammo != 2'd0);
    case (state)
      IDLE, GAME_OVER: if (start) state_nxt = ROUND_START;
      ROUND_START:     if (frame_done) state_nxt = FLY;
      FLY: begin
        if (shot_ok)
          state_nxt = FLASH;
        else if (frame_tick && (fly_cnt == YW'(FLY_FRAMES - 1)))
          state_nxt = ESCAPE;
      end
      FLASH: begin
        if (frame_done) begin
          if (shot_hit)            state_nxt = FALL;
          else if (ammo == 2'd0)   state_nxt = ESCAPE;
          else                     state_nxt = FLY;
        end
      end
      FALL, ESCAPE:    if (frame_done) state_nxt = NEXT;
      NEXT: begin
        if (ducks_done == DW'(DUCKS_PER_ROUND - 1)) state_nxt = ROUND_END;
        else                                        state_nxt = FLY;
      end
      ROUND_END: begin
        if (round_hits >= DW'(PASS_HITS)) state_nxt = ROUND_START;
        else                              state_nxt = GAME_OVER;
      end
      default:         state_nxt = IDLE;
    endcase
    launch = (state_nxt == FLY) && ((state == ROUND_START) || (state == NEXT));
    enter  = (state_nxt != state);
  end

  // State, counters, game bookkeeping and registered outputs. Outputs are
  // decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      fly_cnt       <= '0;
      ducks_done    <= '0;
      round_hits    <= '0;
      shot_hit      <= 1'b0;
      ammo          <= 2'd0;
      score         <= 8'd0;
      round         <= 4'd0;
      duck_en       <= 1'b0;
      duck_respawn  <= 1'b0;
      duck_falling  <= 1'b0;
      duck_escaping <= 1'b0;
      flash_en      <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (enter)           frame_cnt <= '0;
      else if (frame_tick) frame_cnt <= frame_cnt + FCW'(1);

      if (((state == IDLE) || (state == GAME_OVER)) && start) begin
        score <= 8'd0;
        round <= 4'd1;
      end

      if (enter && (state_nxt == ROUND_START)) begin
        ducks_done <= '0;
        round_hits <= '0;
      end

      if ((state == ROUND_END) && (state_nxt == ROUND_START) && (round != 4'hF))
        round <= round + 4'd1;

      if (launch) begin
        ammo    <= 2'(AMMO_PER_DUCK);
        fly_cnt <= '0;
      end

      if (shot_ok) begin
        ammo     <= ammo - 2'd1;
        shot_hit <= hit;
      end else if ((state == FLY) && frame_tick) begin
        fly_cnt <= fly_cnt + YW'(1);
      end

      if ((state == FLASH) && frame_done && shot_hit) begin
        if (score != 8'hFF) score <= score + 8'd1;
        round_hits <= round_hits + DW'(1);
      end

      if (state == NEXT) ducks_done <= ducks_done + DW'(1);

      duck_en       <= (state_nxt == FLY) || (state_nxt == FLASH) ||
                       (state_nxt == FALL) || (state_nxt == ESCAPE);
      duck_respawn  <= launch;
      duck_falling  <= (state_nxt == FALL);
      duck_escaping <= (state_nxt == ESCAPE);
      flash_en      <= (state_nxt == FLASH);
      game_over     <= (state_nxt == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_dh_game_ctl.sv
// tb_dh_game_ctl - self-checking bench for dh_game_ctl.
//
// A frame-countdown model of the game rules runs beside the DUT and every
// output is compared on each falling clock edge; directed game sequences
// add hand-computed literal checks (tick counts, ammo, score, round).
module tb_dh_game_ctl;

  localparam int AMMO = 3;
  localparam int RSF  = 120;
  localparam int FLYF = 300;
  localparam int FLF  = 2;
  localparam int FALF = 60;
  localparam int ESCF = 60;
  localparam int DPR  = 10;
  localparam int PASS = 6;

  localparam int P_IDLE = 0, P_RS = 1, P_FLY = 2, P_FLASH = 3, P_FALL = 4,
                 P_ESC = 5, P_NEXT = 6, P_END = 7, P_OVER = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       trigger = 1'b0;
  logic       hit = 1'b0;
  logic       duck_en, duck_respawn, duck_falling, duck_escaping, flash_en, game_over;
  logic [1:0] ammo;
  logic [7:0] score;
  logic [3:0] round;

  int checks = 0;
  int errors = 0;
  int tick_total = 0;
  int tick_phase = 0;
  bit chk_en = 1'b0;

  int m_phase, m_left, m_fly_left, m_ammo, m_score, m_round, m_ducks, m_hits;
  bit m_shot, m_resp;

  dh_game_ctl #(
    .AMMO_PER_DUCK(AMMO), .ROUND_START_FRAMES(RSF), .FLY_FRAMES(FLYF),
    .FLASH_FRAMES(FLF), .FALL_FRAMES(FALF), .ESCAPE_FRAMES(ESCF),
    .DUCKS_PER_ROUND(DPR), .PASS_HITS(PASS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .trigger(trigger), .hit(hit), .duck_en(duck_en), .duck_respawn(duck_respawn),
    .duck_falling(duck_falling), .duck_escaping(duck_escaping), .flash_en(flash_en),
    .ammo(ammo), .score(score), .round(round), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each timed phase holds a countdown of frames still to wait.
  task automatic launchDuck();
    m_phase    <= P_FLY;
    m_ammo     <= AMMO;
    m_fly_left <= FLYF;
    m_resp     <= 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE; m_left <= 0; m_fly_left <= 0; m_ammo <= 0;
      m_score <= 0; m_round <= 0; m_ducks <= 0; m_hits <= 0;
      m_shot <= 1'b0; m_resp <= 1'b0;
    end else begin
      m_resp <= 1'b0;
      case (m_phase)
        P_IDLE, P_OVER: if (start) begin
          m_score <= 0; m_round <= 1; m_hits <= 0; m_ducks <= 0;
          m_phase <= P_RS; m_left <= RSF;
        end
        P_RS: if (frame_tick) begin
          if (m_left == 1) launchDuck(); else m_left <= m_left - 1;
        end
        P_FLY: begin
          if (trigger && m_ammo > 0) begin
            m_ammo <= m_ammo - 1; m_shot <= hit; m_phase <= P_FLASH; m_left <= FLF;
          end else if (frame_tick) begin
            if (m_fly_left == 1) begin m_phase <= P_ESC; m_left <= ESCF; end
            else m_fly_left <= m_fly_left - 1;
          end
        end
        P_FLASH: if (frame_tick) begin
          if (m_left == 1) begin
            if (m_shot) begin
              m_score <= (m_score < 255) ? m_score + 1 : 255;
              m_hits <= m_hits + 1; m_phase <= P_FALL; m_left <= FALF;
            end else if (m_ammo == 0) begin
              m_phase <= P_ESC; m_left <= ESCF;
            end else begin
              m_phase <= P_FLY;
            end
          end else m_left <= m_left - 1;
        end
        P_FALL, P_ESC: if (frame_tick) begin
          if (m_left == 1) m_phase <= P_NEXT; else m_left <= m_left - 1;
        end
        P_NEXT: begin
          m_ducks <= m_ducks + 1;
          if (m_ducks + 1 == DPR) m_phase <= P_END; else launchDuck();
        end
        P_END: begin
          if (m_hits >= PASS) begin
            m_round <= (m_round < 15) ? m_round + 1 : 15;
            m_hits <= 0; m_ducks <= 0; m_phase <= P_RS; m_left <= RSF;
          end else m_phase <= P_OVER;
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("duck_en", duck_en, (m_phase == P_FLY || m_phase == P_FLASH ||
                                       m_phase == P_FALL || m_phase == P_ESC));
      checkOutput("duck_respawn", duck_respawn, m_resp);
      checkOutput("duck_falling", duck_falling, m_phase == P_FALL);
      checkOutput("duck_escaping", duck_escaping, m_phase == P_ESC);
      checkOutput("flash_en", flash_en, m_phase == P_FLASH);
      checkOutput("game_over", game_over, m_phase == P_OVER);
      checkOutput("ammo", ammo, m_ammo);
      checkOutput("score", score, m_score);
      checkOutput("round", round, m_round);
    end
  end

  // One clock cycle of stimulus; frame_tick fires every fourth cycle.
  task automatic applyStimulus(input logic s, input logic t, input logic h);
    @(negedge clk);
    start = s; trigger = t; hit = h;
    frame_tick = (tick_phase == 0);
    if (tick_phase == 0) tick_total++;
    tick_phase = (tick_phase + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  function automatic logic dutSig(input int w);
    case (w)
      0:       return flash_en;
      1:       return duck_falling;
      2:       return duck_escaping;
      3:       return duck_en && !flash_en && !duck_falling && !duck_escaping;
      4:       return !duck_respawn;
      5:       return !game_over;
      default: return 1'b0;
    endcase
  endfunction

  task automatic holdWhile(input int w, input string name);
    int n = 0;
    while (dutSig(w) && n < 2000) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 2000) begin
      checkOutput({"timeout_", name}, 0, 1);
      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  task automatic playDuck(input bit is_hit);
    holdWhile(4, "respawn");
    if (is_hit) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      holdWhile(0, "flash");
      holdWhile(1, "fall");
    end else begin
      for (int i = 0; i < AMMO; i++) begin
        applyStimulus(1'b0, 1'b1, 1'b0);
        holdWhile(0, "flash");
      end
      holdWhile(2, "escape");
    end
  endtask

  // Directed game sequences with literal expectations.
  initial begin
    int t0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom); trigger = 1'($urandom);
      hit = 1'($urandom); frame_tick = 1'($urandom);
      @(posedge clk);
      #1;
    end
    checkOutput("lit_rst_duck_en", duck_en, 0);
    checkOutput("lit_rst_score", score, 0);
    checkOutput("lit_rst_round", round, 0);
    checkOutput("lit_rst_ammo", ammo, 0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; trigger = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    tick_phase = 1;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lit_idle_duck_en", duck_en, 0);
    checkOutput("lit_idle_round", round, 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lit_start_round", round, 1);
    checkOutput("lit_start_duck_en", duck_en, 0);
    t0 = tick_total;
    holdWhile(4, "respawn");
    checkOutput("lit_intro_ticks", tick_total - t0, 120);
    checkOutput("lit_first_ammo", ammo, 3);
    checkOutput("lit_first_duck_en", duck_en, 1);

    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("lit_hit_ammo", ammo, 2);
    checkOutput("lit_hit_flash", flash_en, 1);
    t0 = tick_total;
    holdWhile(0, "flash");
    checkOutput("lit_flash_ticks", tick_total - t0, 2);
    checkOutput("lit_hit_score", score, 1);
    checkOutput("lit_hit_falling", duck_falling, 1);
    t0 = tick_total;
    holdWhile(1, "fall");
    checkOutput("lit_fall_ticks", tick_total - t0, 60);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lit_respawn2", duck_respawn, 1);
    checkOutput("lit_respawn2_ammo", ammo, 3);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("lit_miss_ammo", ammo, 2 - i);
      holdWhile(0, "flash");
    end
    checkOutput("lit_miss_escaping", duck_escaping, 1);
    t0 = tick_total;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lit_4th_trigger_flash", flash_en, 0);
    checkOutput("lit_4th_trigger_ammo", ammo, 0);
    holdWhile(2, "escape");
    checkOutput("lit_escape_ticks", tick_total - t0, 60);

    holdWhile(4, "respawn");
    t0 = tick_total;
    holdWhile(3, "fly");
    checkOutput("lit_fly_ticks", tick_total - t0, 300);
    checkOutput("lit_timeout_escaping", duck_escaping, 1);
    holdWhile(2, "escape");

    holdWhile(4, "respawn");
    t0 = tick_total;
    while (tick_total - t0 < 299) applyStimulus(1'b0, 1'b0, 1'b0);
    while (tick_phase != 0) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("lit_edge_flash", flash_en, 1);
    checkOutput("lit_edge_escaping", duck_escaping, 0);
    holdWhile(0, "flash");
    holdWhile(1, "fall");

    for (int i = 0; i < 4; i++) playDuck(1'b1);
    for (int i = 0; i < 2; i++) playDuck(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lit_pass_round", round, 2);
    checkOutput("lit_pass_score", score, 6);
    checkOutput("lit_pass_game_over", game_over, 0);

    for (int i = 0; i < 5; i++) playDuck(1'b1);
    for (int i = 0; i < 5; i++) playDuck(1'b0);
    holdWhile(5, "game_over");
    checkOutput("lit_fail_game_over", game_over, 1);
    checkOutput("lit_fail_score", score, 11);
    checkOutput("lit_fail_round", round, 2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lit_hold_score", score, 11);
    checkOutput("lit_hold_flash", flash_en, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lit_restart_score", score, 0);
    checkOutput("lit_restart_round", round, 1);
    checkOutput("lit_restart_game_over", game_over, 0);

    holdWhile(4, "respawn");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lit_pre_reset_flash", flash_en, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("lit_async_flash", flash_en, 0);
    checkOutput("lit_async_duck_en", duck_en, 0);
    checkOutput("lit_async_ammo", ammo, 0);
    checkOutput("lit_async_round", round, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
